// File: rtl/rpn_stack_engine.sv
// rpn_stack_engine: hardware RPN stack with registered TOS, a DEPTH-1 entry
// synchronous-read memory below it, an integrated ALU and sticky
// overflow/underflow error handling behind a valid/ready command port.
module rpn_stack_engine #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16,
   parameter int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             CLOCK_50,
   input  logic             RESET_N,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [2:0]       cmd_op,
   input  logic [WIDTH-1:0] cmd_data,
   input  logic             err_clr,
   output logic [WIDTH-1:0] top,
   output logic [CNT_W-1:0] count,
   output logic             overflow,
   output logic             underflow,
   output logic             busy
);

   localparam int AW = (DEPTH > 2) ? $clog2(DEPTH - 1) : 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_READ,
      S_EXEC,
      S_ERROR
   } state_t;

   typedef enum logic [2:0] {
      OP_PUSH = 3'b000,
      OP_POP  = 3'b001,
      OP_ADD  = 3'b010,
      OP_SUB  = 3'b011,
      OP_MUL  = 3'b100,
      OP_AND  = 3'b101,
      OP_OR   = 3'b110,
      OP_SWAP = 3'b111
   } op_t;

   state_t           state;
   op_t              op_in;
   op_t              op_lat;
   logic [WIDTH-1:0] tos;
   logic [WIDTH-1:0] q;
   logic [WIDTH-1:0] alu;
   logic [WIDTH-1:0] mem [0:DEPTH-2];

   logic             accept;
   logic             mem_we;
   logic [AW-1:0]    mem_waddr;
   logic [WIDTH-1:0] mem_wdata;
   logic             mem_re;
   logic [AW-1:0]    mem_raddr;

   assign top       = tos;
   assign cmd_ready = (state == S_IDLE) && !overflow && !underflow;

   // Command decode and memory port control; writes are suppressed during reset
   always_comb begin
      op_in     = op_t'(cmd_op);
      accept    = cmd_valid && cmd_ready;
      mem_we    = 1'b0;
      mem_waddr = '0;
      mem_wdata = tos;
      mem_re    = 1'b0;
      mem_raddr = AW'(count - CNT_W'(2));
      if (RESET_N) begin
         if (state == S_IDLE && accept && op_in == OP_PUSH &&
             count != '0 && count != CNT_W'(DEPTH)) begin
            mem_we    = 1'b1;
            mem_waddr = AW'(count - CNT_W'(1));
         end else if (state == S_EXEC && op_lat == OP_SWAP) begin
            mem_we    = 1'b1;
            mem_waddr = AW'(count - CNT_W'(2));
         end
      end
      if (state == S_IDLE && accept && op_in != OP_PUSH && count >= CNT_W'(2))
         mem_re = 1'b1;
   end

   // ALU: NOS (memory q) op TOS, all results modulo 2^WIDTH
   always_comb begin
      alu = q;
      case (op_lat)
         OP_ADD:  alu = q + tos;
         OP_SUB:  alu = q - tos;
         OP_MUL:  alu = q * tos;
         OP_AND:  alu = q & tos;
         OP_OR:   alu = q | tos;
         default: alu = q;
      endcase
   end

   // Stack body: synchronous write and synchronous read, no reset on contents
   always_ff @(posedge CLOCK_50) begin
      if (mem_we)
         mem[mem_waddr] <= mem_wdata;
      if (mem_re)
         q <= mem[mem_raddr];
   end

   // Control FSM with registered TOS, count, busy and sticky error flags
   always_ff @(posedge CLOCK_50) begin
      if (!RESET_N) begin
         state     <= S_IDLE;
         op_lat    <= OP_PUSH;
         tos       <= '0;
         count     <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
         busy      <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (accept) begin
                  case (op_in)
                     OP_PUSH: begin
                        if (count == CNT_W'(DEPTH)) begin
                           overflow <= 1'b1;
                           state    <= S_ERROR;
                        end else begin
                           tos   <= cmd_data;
                           count <= count + CNT_W'(1);
                        end
                     end
                     OP_POP: begin
                        if (count == '0) begin
                           underflow <= 1'b1;
                           state     <= S_ERROR;
                        end else begin
                           op_lat <= op_in;
                           busy   <= 1'b1;
                           state  <= S_READ;
                        end
                     end
                     default: begin
                        if (count < CNT_W'(2)) begin
                           underflow <= 1'b1;
                           state     <= S_ERROR;
                        end else begin
                           op_lat <= op_in;
                           busy   <= 1'b1;
                           state  <= S_READ;
                        end
                     end
                  endcase
               end
            end
            S_READ: begin
               state <= S_EXEC;
            end
            S_EXEC: begin
               case (op_lat)
                  OP_POP: begin
                     tos   <= (count == CNT_W'(1)) ? '0 : q;
                     count <= count - CNT_W'(1);
                  end
                  OP_SWAP: begin
                     tos <= q;
                  end
                  default: begin
                     tos   <= alu;
                     count <= count - CNT_W'(1);
                  end
               endcase
               busy  <= 1'b0;
               state <= S_IDLE;
            end
            S_ERROR: begin
               if (err_clr) begin
                  overflow  <= 1'b0;
                  underflow <= 1'b0;
                  state     <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_rpn_stack_engine.sv
// Testbench for rpn_stack_engine: a queue-based stack model predicts every
// output each cycle, plus directed sequences with literal expectations.
module tb_rpn_stack_engine;

   localparam int W  = 8;
   localparam int D  = 4;
   localparam int CW = $clog2(D + 1);

   typedef logic [W-1:0] word_t;

   logic          CLOCK_50 = 1'b0;
   logic          RESET_N  = 1'b0;
   logic          cmd_valid = 1'b0;
   logic          err_clr   = 1'b0;
   logic [2:0]    cmd_op    = '0;
   word_t         cmd_data  = '0;
   logic          cmd_ready;
   logic          overflow;
   logic          underflow;
   logic          busy;
   word_t         top;
   logic [CW-1:0] count;

   int n_tests = 0;
   int n_fail  = 0;
   bit check_en = 1'b0;

   // Reference model state
   word_t stk[$];
   word_t pend[$];
   bit    m_ovf = 1'b0;
   bit    m_unf = 1'b0;
   int    m_busy = 0;
   word_t ma, mb, mr;

   rpn_stack_engine #(.WIDTH(W), .DEPTH(D)) dut (
      .CLOCK_50  (CLOCK_50),
      .RESET_N   (RESET_N),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_op    (cmd_op),
      .cmd_data  (cmd_data),
      .err_clr   (err_clr),
      .top       (top),
      .count     (count),
      .overflow  (overflow),
      .underflow (underflow),
      .busy      (busy)
   );

   always #5 CLOCK_50 = ~CLOCK_50;

   function automatic bit m_ready();
      return (m_busy == 0) && !m_ovf && !m_unf;
   endfunction

   function automatic word_t m_top();
      return (stk.size() > 0) ? stk[stk.size() - 1] : '0;
   endfunction

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, got, exp);
      end
   endtask

   // Transaction-level model: a non-PUSH op computes its result at accept and
   // publishes it after two busy cycles.
   always @(posedge CLOCK_50) begin
      if (!RESET_N) begin
         stk.delete();
         pend.delete();
         m_ovf  = 1'b0;
         m_unf  = 1'b0;
         m_busy = 0;
      end else if (m_busy > 0) begin
         m_busy--;
         if (m_busy == 0) stk = pend;
      end else if (m_ovf || m_unf) begin
         if (err_clr) begin
            m_ovf = 1'b0;
            m_unf = 1'b0;
         end
      end else if (cmd_valid) begin
         if (cmd_op == 3'd0) begin
            if (stk.size() == D) m_ovf = 1'b1;
            else stk.push_back(cmd_data);
         end else if (cmd_op == 3'd1) begin
            if (stk.size() == 0) m_unf = 1'b1;
            else begin
               pend = stk;
               void'(pend.pop_back());
               m_busy = 2;
            end
         end else begin
            if (stk.size() < 2) m_unf = 1'b1;
            else begin
               ma = stk[stk.size() - 2];
               mb = stk[stk.size() - 1];
               pend = stk;
               void'(pend.pop_back());
               void'(pend.pop_back());
               case (cmd_op)
                  3'd2: mr = ma + mb;
                  3'd3: mr = ma - mb;
                  3'd4: mr = ma * mb;
                  3'd5: mr = ma & mb;
                  3'd6: mr = ma | mb;
                  default: mr = ma;
               endcase
               if (cmd_op == 3'd7) begin
                  pend.push_back(mb);
                  pend.push_back(ma);
               end else begin
                  pend.push_back(mr);
               end
               m_busy = 2;
            end
         end
      end
   end

   // Per-cycle comparison of every output against the model
   always @(negedge CLOCK_50) begin
      if (check_en) begin
         chk("top", top, m_top());
         chk("count", count, stk.size());
         chk("overflow", overflow, m_ovf);
         chk("underflow", underflow, m_unf);
         chk("busy", busy, m_busy > 0);
         chk("cmd_ready", cmd_ready, m_ready());
      end
   end

   task automatic wait_ready();
      int k = 0;
      while (!m_ready() && k < 20) begin
         @(negedge CLOCK_50);
         k++;
      end
      if (!m_ready()) chk("ready_timeout", 0, 1);
   endtask

   task automatic issue(input logic [2:0] op, input word_t d);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_data  = d;
      wait_ready();
      @(posedge CLOCK_50);
      #1;
   endtask

   task automatic idle();
      cmd_valid = 1'b0;
   endtask

   task automatic clr();
      err_clr = 1'b1;
      @(posedge CLOCK_50);
      #1;
      err_clr = 1'b0;
   endtask

   task automatic do_reset();
      RESET_N   = 1'b0;
      cmd_valid = 1'b0;
      err_clr   = 1'b0;
      repeat (2) @(posedge CLOCK_50);
      #1;
      RESET_N = 1'b1;
   endtask

   initial begin
      do_reset();
      check_en = 1'b1;
      chk("rst_top", top, 0);
      chk("rst_count", count, 0);
      chk("rst_ready", cmd_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_flags", {overflow, underflow}, 0);

      // 5 - 3 with the three-cycle op latency
      issue(3'd0, 8'd5);
      issue(3'd0, 8'd3);
      issue(3'd3, 8'd0);
      idle();
      chk("sub_busy_t0", busy, 1);
      chk("sub_ready_t0", cmd_ready, 0);
      @(posedge CLOCK_50); #1;
      chk("sub_busy_t1", busy, 1);
      @(posedge CLOCK_50); #1;
      chk("sub_ready_t2", cmd_ready, 1);
      chk("sub_top", top, 2);
      chk("sub_count", count, 1);
      chk("sub_model_top", m_top(), 2);

      // Wrapping ADD and truncated MUL
      do_reset();
      issue(3'd0, 8'hF0);
      issue(3'd0, 8'h20);
      issue(3'd2, 8'h00);
      idle();
      wait_ready();
      chk("add_wrap", top, 8'h10);
      chk("add_model", m_top(), 8'h10);
      issue(3'd0, 8'h10);
      issue(3'd4, 8'h00);
      idle();
      wait_ready();
      chk("mul_low", top, 8'h00);
      chk("mul_count", count, 1);

      // Overflow on a full stack, then drain
      do_reset();
      for (int i = 1; i <= 5; i++) issue(3'd0, word_t'(i));
      idle();
      chk("ovf_flag", overflow, 1);
      chk("ovf_count", count, 4);
      chk("ovf_top", top, 4);
      chk("ovf_ready", cmd_ready, 0);
      clr();
      chk("ovf_clr", {overflow, underflow}, 0);
      for (int i = 4; i >= 1; i--) begin
         wait_ready();
         chk("drain_top", top, i);
         issue(3'd1, 8'h00);
         idle();
      end
      wait_ready();
      chk("drain_empty", count, 0);
      chk("drain_top0", top, 0);

      // Underflow cases
      issue(3'd1, 8'h00);
      idle();
      chk("unf_pop", underflow, 1);
      chk("unf_pop_count", count, 0);
      clr();
      issue(3'd0, 8'd7);
      issue(3'd2, 8'h00);
      idle();
      chk("unf_add", underflow, 1);
      chk("unf_add_top", top, 7);
      clr();

      // SWAP then POP
      do_reset();
      issue(3'd0, 8'd1);
      issue(3'd0, 8'd2);
      issue(3'd7, 8'h00);
      idle();
      wait_ready();
      chk("swap_top", top, 1);
      issue(3'd1, 8'h00);
      idle();
      wait_ready();
      chk("swap_pop_top", top, 2);
      chk("swap_pop_count", count, 1);

      // Reset during READ abandons the op
      do_reset();
      issue(3'd0, 8'd1);
      issue(3'd0, 8'd2);
      issue(3'd2, 8'h00);
      idle();
      RESET_N = 1'b0;
      @(posedge CLOCK_50); #1;
      chk("mid_rst_count", count, 0);
      chk("mid_rst_top", top, 0);
      chk("mid_rst_busy", busy, 0);
      RESET_N = 1'b1;

      // Randomized traffic checked by the model every cycle
      for (int n = 0; n < 400; n++) begin
         logic [2:0] op;
         if (m_ovf || m_unf) begin
            idle();
            clr();
         end
         op = 3'($urandom_range(0, 7));
         if ($urandom_range(0, 2) == 0) op = 3'd0;
         issue(op, word_t'($urandom));
         if ($urandom_range(0, 3) == 0) begin
            idle();
            if ($urandom_range(0, 1) == 0) err_clr = 1'b1;
            repeat ($urandom_range(1, 3)) begin
               @(posedge CLOCK_50); #1;
            end
            err_clr = 1'b0;
         end
      end
      idle();
      repeat (4) @(posedge CLOCK_50);
      @(negedge CLOCK_50);
      check_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
